lmsm_sequencer: RTL and testbench
=================================

Name: lmsm_sequencer

Overview:
Decode-stage controller that expands one LM (opcode 4'b0110) or SM (opcode 4'b0111) instruction into a stream of single-register micro-ops, one per cycle.
It walks the 8-bit register list in IR[7:0] and emits, per micro-op, the register index, the memory offset from base register RA (IR[11:9]), and load/store type.
It holds fetch and the IF/ID register until the last micro-op issues.
It sits between the IF/ID pipeline register and the ID/RR register, alongside the PC-mux hazard logic.

Parameters:
INSTR_W, 16, instruction width
NUM_REGS, 8, architectural registers; register list width
RIDX_W, 3, register index / offset width (log2 NUM_REGS)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
instr_valid  in  1  IF/ID holds a valid instruction
instr  in  INSTR_W  IF/ID instruction register
stall_in  in  1  downstream hold; sequencer freezes
flush  in  1  branch/jump redirect; kill in-flight sequence
stall_fetch  out  1  hold PC and IF/ID register
busy  out  1  sequence in progress (state SEQ)
uop_valid  out  1  micro-op valid this cycle
uop_load  out  1  micro-op is a load (LM)
uop_store  out  1  micro-op is a store (SM)
uop_reg  out  RIDX_W  register written (LM) or read (SM)
uop_base  out  RIDX_W  base register RA
uop_offset  out  RIDX_W  address offset: base + uop_offset
uop_last  out  1  final micro-op of the sequence

Behaviour:
- Single clock domain. Reset is synchronous and active-low: reset_n sampled low at a clk rising edge forces state IDLE, mask=0, offset=0, and all registered outputs to 0.
- States: IDLE and SEQ.
- IDLE:
  - An LM/SM is accepted when instr_valid=1, instr[15:12] is LM/SM, instr[7:0]!=0, flush=0 and stall_in=0. On acceptance the next edge captures mask=instr[7:0], base=instr[11:9], type and offset=0, and the state goes to SEQ.
  - stall_fetch is driven combinationally high during the acceptance cycle.
  - An LM/SM with an empty list is passed through as a NOP: no micro-ops, no stall.
  - Non-LM/SM instructions produce no output.
- SEQ:
  - Each cycle with stall_in=0 and flush=0:
    - uop_valid=1.
    - uop_reg = index of the lowest set bit of mask (ascending R0..R7).
    - uop_offset = current offset.
  - At the edge, that bit clears and offset increments by 1. Offset does not wrap: it stays ≤7 because at most 8 bits are set.
  - uop_last=1 when mask has exactly one bit set. On the edge after the last micro-op the state returns to IDLE and stall_fetch deasserts in that next cycle.
- stall_fetch = acceptance condition OR (state SEQ AND NOT (uop_last AND uop_valid AND not stall_in)).
- stall_in=1 in SEQ: micro-op outputs hold their values with uop_valid=0, and mask and offset are unchanged.
- flush=1 (any state): uop_valid is forced 0 in the same cycle. The next edge returns to IDLE with mask=0. Flush has priority over acceptance and issue.
- reset_n low mid-sequence: the sequence is aborted and no further micro-ops are emitted.
- Latency: the first micro-op appears 1 cycle after acceptance. An N-register list takes N issue cycles.
- uop_load and uop_store are mutually exclusive and valid only with uop_valid.

Optional Feature:
LMSM_PC_WRITE_EN: adds output port uop_pc_write (1 bit).
- With the macro: uop_pc_write=1 on an LM micro-op whose uop_reg=3'b111. Once that micro-op issues, the remaining list is still issued, and the PC-mux logic selects the load result.
- Without the macro: the port is absent, and R7 is treated as an ordinary register.

Decomposition:
- Shared package lmsm_pkg holds:
  - opcode constants OP_LM=4'b0110 and OP_SM=4'b0111
  - state enum {ST_IDLE, ST_SEQ}
  - RIDX_W and NUM_REGS constants
- One sub-module, lmsm_prio_enc: combinational lowest-set-bit finder over NUM_REGS bits. Outputs the index and a one_hot_last flag (popcount==1).

Test Plan:
- LM base R2, list 8'b1010_0101 -> 4 micro-ops, regs 0,2,5,7, offsets 0..3, uop_last on reg 7. stall_fetch high for 4 cycles total; busy low afterwards.
- SM list 8'b0000_0001 -> one micro-op, reg 0, offset 0, uop_store=1, uop_last=1. stall_fetch high for 1 cycle only.
- LM list 8'h00 -> no micro-ops, stall_fetch stays 0, next instruction flows.
- LM list 8'hFF with stall_in high for 2 cycles after the 3rd micro-op -> outputs held, uop_valid=0 while stalled. Remaining regs 3..7 resume with offsets 3..7.
- LM list 8'hF0, flush asserted during the 2nd micro-op -> that micro-op is suppressed, IDLE next cycle, no further micro-ops.
- reset_n low mid-sequence, then high -> IDLE with all outputs 0. With LMSM_PC_WRITE_EN, LM list 8'h80 -> uop_pc_write=1 with reg 7.

Source files
------------

// File: rtl/lmsm_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: opcodes, FSM states, sizes.
package lmsm_pkg;

  localparam int NUM_REGS = 8;
  localparam int RIDX_W   = 3;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit finder over the register list.
// o_idx is the index of the lowest set bit (0 when the list is empty).
// o_one_hot_last is high when exactly one bit is set.
module lmsm_prio_enc #(
  parameter int NUM_REGS = lmsm_pkg::NUM_REGS,
  parameter int RIDX_W   = lmsm_pkg::RIDX_W
) (
  input  logic [NUM_REGS-1:0] i_mask,
  output logic [RIDX_W-1:0]   o_idx,
  output logic                o_one_hot_last
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = RIDX_W'(i);
    end
  end

  // Non-empty and clearing the lowest bit leaves nothing: exactly one bit set.
  assign o_one_hot_last = (i_mask != '0) &&
                          ((i_mask & (i_mask - NUM_REGS'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM decode-stage sequencer: expands one load/store-multiple instruction
// into one single-register micro-op per cycle, holding fetch meanwhile.
// busy mirrors the FSM state (high in ST_SEQ) and serves as its state view.
// Handshake: a micro-op transfers in any cycle where uop_valid=1; stall_in=1
// freezes the sequencer with outputs held and uop_valid=0; flush=1 kills
// the sequence in the same cycle.
// Optional macro LMSM_PC_WRITE_EN adds uop_pc_write for LM loads into R7.
module lmsm_sequencer #(
  parameter int INSTR_W  = 16,
  parameter int NUM_REGS = lmsm_pkg::NUM_REGS,
  parameter int RIDX_W   = lmsm_pkg::RIDX_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall_in,
  input  logic               flush,
  output logic               stall_fetch,
  output logic               busy,
  output logic               uop_valid,
  output logic               uop_load,
  output logic               uop_store,
  output logic [RIDX_W-1:0]  uop_reg,
  output logic [RIDX_W-1:0]  uop_base,
  output logic [RIDX_W-1:0]  uop_offset,
`ifdef LMSM_PC_WRITE_EN
  output logic               uop_pc_write,
`endif
  output logic               uop_last
);

  import lmsm_pkg::*;

  state_t                r_state, w_state_nxt;
  logic [NUM_REGS-1:0]   r_mask,  w_mask_nxt;
  logic [RIDX_W-1:0]     r_offset, w_offset_nxt;
  logic [RIDX_W-1:0]     r_base,  w_base_nxt;
  logic                  r_load,  w_load_nxt;

  logic [RIDX_W-1:0]     w_idx;
  logic                  w_one_hot_last;
  logic [3:0]            w_opcode;
  logic                  w_is_lmsm;
  logic                  w_accept;
  logic                  w_seq;
  logic                  w_issue;
  logic                  w_unused_bit;

  assign w_opcode     = instr[15:12];
  assign w_unused_bit = instr[8];

  lmsm_prio_enc #(
    .NUM_REGS (NUM_REGS),
    .RIDX_W   (RIDX_W)
  ) u_prio_enc (
    .i_mask         (r_mask),
    .o_idx          (w_idx),
    .o_one_hot_last (w_one_hot_last)
  );

  assign w_is_lmsm = (w_opcode == OP_LM) || (w_opcode == OP_SM);
  assign w_seq     = (r_state == ST_SEQ);
  // Empty-list LM/SM never qualifies, so it flows through as a NOP.
  assign w_accept  = (r_state == ST_IDLE) && instr_valid && w_is_lmsm &&
                     (instr[NUM_REGS-1:0] != '0) && !flush && !stall_in;
  assign w_issue   = w_seq && !flush && !stall_in;

  // State and sequence registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_offset <= '0;
      r_base   <= '0;
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_offset <= w_offset_nxt;
      r_base   <= w_base_nxt;
      r_load   <= w_load_nxt;
    end
  end

  // Next-state: flush wins, then acceptance in IDLE, then issue in SEQ.
  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_offset_nxt = r_offset;
    w_base_nxt   = r_base;
    w_load_nxt   = r_load;
    if (flush) begin
      w_state_nxt  = ST_IDLE;
      w_mask_nxt   = '0;
      w_offset_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt  = ST_SEQ;
            w_mask_nxt   = instr[NUM_REGS-1:0];
            w_base_nxt   = instr[11:9];
            w_load_nxt   = (w_opcode == OP_LM);
            w_offset_nxt = '0;
          end
        end
        ST_SEQ: begin
          if (w_issue) begin
            // Clear the lowest set bit, i.e. the register just issued.
            w_mask_nxt = r_mask & (r_mask - NUM_REGS'(1));
            if (w_one_hot_last) begin
              w_state_nxt  = ST_IDLE;
              w_offset_nxt = '0;
            end else begin
              w_offset_nxt = r_offset + RIDX_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end
      endcase
    end
  end

  // Micro-op outputs: fields follow the held state, so a stall keeps them steady.
  always_comb begin
    busy        = w_seq;
    uop_valid   = w_issue;
    uop_load    = w_issue && r_load;
    uop_store   = w_issue && !r_load;
    uop_reg     = w_seq ? w_idx    : '0;
    uop_base    = w_seq ? r_base   : '0;
    uop_offset  = w_seq ? r_offset : '0;
    uop_last    = w_seq && w_one_hot_last;
    stall_fetch = w_accept || (w_seq && !(w_one_hot_last && w_issue));
  end

`ifdef LMSM_PC_WRITE_EN
  // A load into R7 redirects the PC through the load result.
  assign uop_pc_write = uop_load && (uop_reg == {RIDX_W{1'b1}});
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer. Each check packs the visible outputs as
// {valid, load, store, reg[2:0], base[2:0], offset[2:0], last, stall_fetch, busy}.
module tb_lmsm_sequencer;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        stall_in;
  logic        flush;
  logic        stall_fetch;
  logic        busy;
  logic        uop_valid;
  logic        uop_load;
  logic        uop_store;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_base;
  logic [2:0]  uop_offset;
  logic        uop_last;
`ifdef LMSM_PC_WRITE_EN
  logic        uop_pc_write;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lmsm_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .stall_in    (stall_in),
    .flush       (flush),
    .stall_fetch (stall_fetch),
    .busy        (busy),
    .uop_valid   (uop_valid),
    .uop_load    (uop_load),
    .uop_store   (uop_store),
    .uop_reg     (uop_reg),
    .uop_base    (uop_base),
    .uop_offset  (uop_offset),
`ifdef LMSM_PC_WRITE_EN
    .uop_pc_write(uop_pc_write),
`endif
    .uop_last    (uop_last)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against a hand-computed vector.
  task automatic expect_o(input string tag, input logic v, input logic ld,
                          input logic st, input logic [2:0] rg,
                          input logic [2:0] bs, input logic [2:0] of,
                          input logic lst, input logic sf, input logic bsy);
    logic [14:0] act;
    logic [14:0] exp;
    #1;
    act = {uop_valid, uop_load, uop_store, uop_reg, uop_base, uop_offset,
           uop_last, stall_fetch, busy};
    exp = {v, ld, st, rg, bs, of, lst, sf, bsy};
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins,
                       input logic st, input logic fl);
    instr_valid = iv;
    instr       = ins;
    stall_in    = st;
    flush       = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    cyc();
    cyc();
    expect_o("reset_state", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    reset_n = 1'b1;
    cyc();

    // LM base R2, list 1010_0101 -> regs 0,2,5,7 offsets 0..3.
    drive(1'b1, 16'h64A5, 1'b0, 1'b0);
    expect_o("lm_a5_accept", 0,0,0, 3'd0,3'd0,3'd0, 0,1,0);
    cyc();
    expect_o("lm_a5_uop0", 1,1,0, 3'd0,3'd2,3'd0, 0,1,1);
    cyc();
    expect_o("lm_a5_uop1", 1,1,0, 3'd2,3'd2,3'd1, 0,1,1);
    cyc();
    expect_o("lm_a5_uop2", 1,1,0, 3'd5,3'd2,3'd2, 0,1,1);
    cyc();
    expect_o("lm_a5_uop3", 1,1,0, 3'd7,3'd2,3'd3, 1,0,1);
`ifdef LMSM_PC_WRITE_EN
    n_tests++;
    assert (uop_pc_write === 1'b1) else begin
      n_fail++;
      $error("FAIL lm_a5_pcw observed=%b expected=1", uop_pc_write);
    end
`endif
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("lm_a5_done", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // SM base R5, list 0000_0001 -> single store, one stall cycle.
    drive(1'b1, 16'h7A01, 1'b0, 1'b0);
    expect_o("sm_01_accept", 0,0,0, 3'd0,3'd0,3'd0, 0,1,0);
    cyc();
    expect_o("sm_01_uop0", 1,0,1, 3'd0,3'd5,3'd0, 1,0,1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("sm_01_done", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // LM with empty list is a NOP; next instruction flows.
    drive(1'b1, 16'h6000, 1'b0, 1'b0);
    expect_o("lm_empty", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    cyc();
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    expect_o("non_lmsm", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    cyc();

    // Acceptance blocked by stall_in and by flush in IDLE.
    drive(1'b1, 16'h64A5, 1'b1, 1'b0);
    expect_o("idle_stall_block", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    cyc();
    drive(1'b1, 16'h64A5, 1'b0, 1'b1);
    expect_o("idle_flush_block", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("idle_after_block", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // LM base R1, list FF, 2-cycle stall after the third micro-op.
    drive(1'b1, 16'h62FF, 1'b0, 1'b0);
    expect_o("lm_ff_accept", 0,0,0, 3'd0,3'd0,3'd0, 0,1,0);
    cyc();
    expect_o("lm_ff_uop0", 1,1,0, 3'd0,3'd1,3'd0, 0,1,1);
    cyc();
    expect_o("lm_ff_uop1", 1,1,0, 3'd1,3'd1,3'd1, 0,1,1);
    cyc();
    expect_o("lm_ff_uop2", 1,1,0, 3'd2,3'd1,3'd2, 0,1,1);
    cyc();
    stall_in = 1'b1;
    expect_o("lm_ff_stall0", 0,0,0, 3'd3,3'd1,3'd3, 0,1,1);
    cyc();
    expect_o("lm_ff_stall1", 0,0,0, 3'd3,3'd1,3'd3, 0,1,1);
    cyc();
    stall_in = 1'b0;
    for (int i = 3; i < 8; i++) begin
      expect_o($sformatf("lm_ff_uop%0d", i), 1,1,0, 3'(i),3'd1,3'(i),
               (i == 7), (i != 7), 1);
      cyc();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("lm_ff_done", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // LM base R3, list F0, flush during the second micro-op.
    drive(1'b1, 16'h66F0, 1'b0, 1'b0);
    expect_o("lm_f0_accept", 0,0,0, 3'd0,3'd0,3'd0, 0,1,0);
    cyc();
    expect_o("lm_f0_uop0", 1,1,0, 3'd4,3'd3,3'd0, 0,1,1);
    cyc();
    flush = 1'b1;
    expect_o("lm_f0_flushed", 0,0,0, 3'd5,3'd3,3'd1, 0,1,1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("lm_f0_idle", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    cyc();
    expect_o("lm_f0_no_more", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // Reset mid-sequence aborts it.
    drive(1'b1, 16'h64A5, 1'b0, 1'b0);
    cyc();
    expect_o("rst_mid_uop0", 1,1,0, 3'd0,3'd2,3'd0, 0,1,1);
    reset_n = 1'b0;
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("rst_mid_held", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);
    reset_n = 1'b1;
    cyc();
    expect_o("rst_mid_after", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    // LM base R0, list 80 -> single load into R7.
    drive(1'b1, 16'h6080, 1'b0, 1'b0);
    cyc();
    expect_o("lm_80_uop0", 1,1,0, 3'd7,3'd0,3'd0, 1,0,1);
`ifdef LMSM_PC_WRITE_EN
    n_tests++;
    assert (uop_pc_write === 1'b1) else begin
      n_fail++;
      $error("FAIL lm_80_pcw observed=%b expected=1", uop_pc_write);
    end
`endif
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    expect_o("lm_80_done", 0,0,0, 3'd0,3'd0,3'd0, 0,0,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
